// File: rtl/register_write_buffer.sv
// register_write_buffer
//
// Write-back queue sitting directly in front of the 32x32 register file
// write port.  Register-write requests from the execute/write-back path are
// queued in order and drained one per cycle into the register file.  Three
// bypass lookup ports (A, B, D) return the newest pending value for the
// address being read, so operand reads in the same cycle still see writes
// that have not yet reached the register file.
//
// Ports:
//   clock                      system clock, rising edge active
//   reset                      synchronous, active-high reset
//   push_valid                 write request present
//   push_ready                 buffer can accept a request (!full && !reset)
//   push_addr / push_data      destination register and write value
//   drain_hold                 when 1, nothing is presented to the register file
//   rf_enable                  register file write enable
//   rf_addr / rf_data          register file RW / PW (0 when rf_enable is 0)
//   look_addr_a/b/d            addresses being read on RA / RB / RD
//   hit_a/b/d                  a pending entry matches the lookup address
//   hit_data_a/b/d             youngest matching pending value, 0 on miss
//   count                      current occupancy, 0..DEPTH

module register_write_buffer #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push_valid,
  output logic                     push_ready,
  input  logic [ADDR_WIDTH-1:0]    push_addr,
  input  logic [DATA_WIDTH-1:0]    push_data,
  input  logic                     drain_hold,
  output logic                     rf_enable,
  output logic [ADDR_WIDTH-1:0]    rf_addr,
  output logic [DATA_WIDTH-1:0]    rf_data,
  input  logic [ADDR_WIDTH-1:0]    look_addr_a,
  input  logic [ADDR_WIDTH-1:0]    look_addr_b,
  input  logic [ADDR_WIDTH-1:0]    look_addr_d,
  output logic                     hit_a,
  output logic                     hit_b,
  output logic                     hit_d,
  output logic [DATA_WIDTH-1:0]    hit_data_a,
  output logic [DATA_WIDTH-1:0]    hit_data_b,
  output logic [DATA_WIDTH-1:0]    hit_data_d,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [CNT_W-1:0]      occupancy;

  logic full;
  logic empty;
  logic push_fire;
  logic drain_fire;

  assign full       = (occupancy == CNT_W'(DEPTH));
  assign empty      = (occupancy == '0);
  assign push_ready = !full && !reset;
  assign rf_enable  = !empty && !drain_hold && !reset;
  assign push_fire  = push_valid && push_ready;
  assign drain_fire = rf_enable;
  assign count      = occupancy;

  // The head entry is offered to the register file combinationally; the
  // register file captures it on the same edge that advances head.
  assign rf_addr = rf_enable ? addr_mem[head] : '0;
  assign rf_data = rf_enable ? data_mem[head] : '0;

  // Queue state.  A push into a full buffer is refused even if the buffer
  // drains on the same edge, so occupancy can never exceed DEPTH.
  always_ff @(posedge clock) begin
    if (reset) begin
      head      <= '0;
      tail      <= '0;
      occupancy <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem[i] <= '0;
        data_mem[i] <= '0;
      end
    end else begin
      if (push_fire) begin
        addr_mem[tail] <= push_addr;
        data_mem[tail] <= push_data;
        tail           <= tail + PTR_W'(1);
      end
      if (drain_fire) begin
        head <= head + PTR_W'(1);
      end
      case ({push_fire, drain_fire})
        2'b10:   occupancy <= occupancy + CNT_W'(1);
        2'b01:   occupancy <= occupancy - CNT_W'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  // Bypass lookup: walk valid entries from oldest (head) to youngest so the
  // last match wins, giving the newest pending value.  Only stored state is
  // examined, so a push arriving this cycle is not visible yet.
  logic [ADDR_WIDTH-1:0] look_addr [3];
  logic                  look_hit  [3];
  logic [DATA_WIDTH-1:0] look_data [3];

  assign look_addr[0] = look_addr_a;
  assign look_addr[1] = look_addr_b;
  assign look_addr[2] = look_addr_d;

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      look_hit[r]  = 1'b0;
      look_data[r] = '0;
      for (int i = 0; i < DEPTH; i++) begin
        if (!reset && (CNT_W'(i) < occupancy) &&
            (addr_mem[head + PTR_W'(i)] == look_addr[r])) begin
          look_hit[r]  = 1'b1;
          look_data[r] = data_mem[head + PTR_W'(i)];
        end
      end
    end
  end

  assign hit_a      = look_hit[0];
  assign hit_b      = look_hit[1];
  assign hit_d      = look_hit[2];
  assign hit_data_a = look_data[0];
  assign hit_data_b = look_data[1];
  assign hit_data_d = look_data[2];

endmodule

// File: tb/tb_register_write_buffer.sv
// tb_register_write_buffer
//
// Directed testbench for register_write_buffer (DEPTH=4).  Inputs are driven
// and outputs sampled around the falling edge, away from the rising edge
// where the buffer updates.

module tb_register_write_buffer;

  logic        clock;
  logic        reset;
  logic        push_valid;
  logic        push_ready;
  logic [4:0]  push_addr;
  logic [31:0] push_data;
  logic        drain_hold;
  logic        rf_enable;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic [4:0]  look_addr_a;
  logic [4:0]  look_addr_b;
  logic [4:0]  look_addr_d;
  logic        hit_a;
  logic        hit_b;
  logic        hit_d;
  logic [31:0] hit_data_a;
  logic [31:0] hit_data_b;
  logic [31:0] hit_data_d;
  logic [2:0]  count;

  int checks;
  int errors;

  register_write_buffer #(
    .DEPTH(4),
    .DATA_WIDTH(32),
    .ADDR_WIDTH(5)
  ) dut (
    .clock(clock),
    .reset(reset),
    .push_valid(push_valid),
    .push_ready(push_ready),
    .push_addr(push_addr),
    .push_data(push_data),
    .drain_hold(drain_hold),
    .rf_enable(rf_enable),
    .rf_addr(rf_addr),
    .rf_data(rf_data),
    .look_addr_a(look_addr_a),
    .look_addr_b(look_addr_b),
    .look_addr_d(look_addr_d),
    .hit_a(hit_a),
    .hit_b(hit_b),
    .hit_d(hit_d),
    .hit_data_a(hit_data_a),
    .hit_data_b(hit_data_b),
    .hit_data_d(hit_data_d),
    .count(count)
  );

  // 10 time-unit clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reset held for two edges, then released.
  task automatic test_reset();
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    checks++;
    if (push_ready !== 1'b0 || rf_enable !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_hold_outputs: push_ready=%0b rf_enable=%0b, required 0/0", push_ready, rf_enable);
    end
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    look_addr_a = 5'd0;
    look_addr_b = 5'd15;
    look_addr_d = 5'd31;
    #1;
    checks++;
    if (push_ready !== 1'b1 || rf_enable !== 1'b0 || count !== 3'd0) begin
      errors++;
      $display("[TB] FAIL reset_release: push_ready=%0b rf_enable=%0b count=%0d, required 1/0/0", push_ready, rf_enable, count);
    end
    checks++;
    if (hit_a !== 1'b0 || hit_b !== 1'b0 || hit_d !== 1'b0 || hit_data_a !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_no_hits: hits=%0b%0b%0b data_a=%0d, required 000/0", hit_a, hit_b, hit_d, hit_data_a);
    end
  endtask

  // One push with drain enabled: presented the cycle after, gone the next.
  task automatic test_single_push();
    @(negedge clock);
    drain_hold = 1'b0;
    push_valid = 1'b1;
    push_addr  = 5'd3;
    push_data  = 32'd20;
    #1;
    checks++;
    if (rf_enable !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_no_passthrough: rf_enable=%0b, required 0", rf_enable);
    end
    @(negedge clock);
    push_valid = 1'b0;
    #1;
    checks++;
    if (rf_enable !== 1'b1 || rf_addr !== 5'd3 || rf_data !== 32'd20 || count !== 3'd1) begin
      errors++;
      $display("[TB] FAIL single_present: en=%0b addr=%0d data=%0d count=%0d, required 1/3/20/1", rf_enable, rf_addr, rf_data, count);
    end
    @(negedge clock);
    checks++;
    if (rf_enable !== 1'b0 || count !== 3'd0 || rf_addr !== 5'd0 || rf_data !== 32'd0) begin
      errors++;
      $display("[TB] FAIL single_drained: en=%0b count=%0d addr=%0d data=%0d, required 0/0/0/0", rf_enable, count, rf_addr, rf_data);
    end
  endtask

  // Fill to DEPTH under hold, try an overflow push, then drain in order.
  task automatic test_fill_and_drain();
    @(negedge clock);
    drain_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_valid = 1'b1;
      push_addr  = 5'(i);
      push_data  = 32'(20 + i);
      @(negedge clock);
    end
    #1;
    checks++;
    if (count !== 3'd4 || push_ready !== 1'b0 || rf_enable !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fill_full: count=%0d push_ready=%0b rf_enable=%0b, required 4/0/0", count, push_ready, rf_enable);
    end
    push_addr = 5'd4;
    push_data = 32'd24;
    @(negedge clock);
    push_valid = 1'b0;
    checks++;
    if (count !== 3'd4) begin
      errors++;
      $display("[TB] FAIL fill_overflow_ignored: count=%0d, required 4", count);
    end
    drain_hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (rf_enable !== 1'b1 || rf_addr !== 5'(i) || rf_data !== 32'(20 + i)) begin
        errors++;
        $display("[TB] FAIL fill_drain_order[%0d]: en=%0b addr=%0d data=%0d, required 1/%0d/%0d", i, rf_enable, rf_addr, rf_data, i, 20 + i);
      end
      @(negedge clock);
    end
    #1;
    checks++;
    if (rf_enable !== 1'b0 || count !== 3'd0) begin
      errors++;
      $display("[TB] FAIL fill_drain_empty: en=%0b count=%0d, required 0/0", rf_enable, count);
    end
  endtask

  // Two pending writes to the same register: the youngest value wins.
  task automatic test_bypass();
    @(negedge clock);
    drain_hold = 1'b1;
    push_valid = 1'b1;
    push_addr  = 5'd7;
    push_data  = 32'd100;
    @(negedge clock);
    push_data = 32'd200;
    @(negedge clock);
    push_addr   = 5'd9;
    push_data   = 32'd55;
    look_addr_a = 5'd7;
    look_addr_b = 5'd31;
    look_addr_d = 5'd9;
    #1;
    checks++;
    if (hit_a !== 1'b1 || hit_data_a !== 32'd200) begin
      errors++;
      $display("[TB] FAIL bypass_youngest: hit_a=%0b data=%0d, required 1/200", hit_a, hit_data_a);
    end
    checks++;
    if (hit_b !== 1'b0 || hit_data_b !== 32'd0) begin
      errors++;
      $display("[TB] FAIL bypass_miss: hit_b=%0b data=%0d, required 0/0", hit_b, hit_data_b);
    end
    checks++;
    if (hit_d !== 1'b0 || hit_data_d !== 32'd0) begin
      errors++;
      $display("[TB] FAIL bypass_push_invisible: hit_d=%0b data=%0d, required 0/0", hit_d, hit_data_d);
    end
    @(negedge clock);
    push_valid = 1'b0;
    checks++;
    if (hit_d !== 1'b1 || hit_data_d !== 32'd55) begin
      errors++;
      $display("[TB] FAIL bypass_after_push: hit_d=%0b data=%0d, required 1/55", hit_d, hit_data_d);
    end
    // Release hold: (7,100) drains, (7,200) is now head and still visible.
    drain_hold = 1'b0;
    @(negedge clock);
    #1;
    checks++;
    if (rf_enable !== 1'b1 || rf_data !== 32'd200 || hit_a !== 1'b1 || hit_data_a !== 32'd200) begin
      errors++;
      $display("[TB] FAIL bypass_head_counts: en=%0b rf_data=%0d hit_a=%0b data=%0d, required 1/200/1/200", rf_enable, rf_data, hit_a, hit_data_a);
    end
    @(negedge clock);
    checks++;
    if (hit_a !== 1'b0 || hit_data_a !== 32'd0 || hit_d !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bypass_after_drain: hit_a=%0b data=%0d hit_d=%0b, required 0/0/1", hit_a, hit_data_a, hit_d);
    end
    @(negedge clock);
    checks++;
    if (count !== 3'd0 || hit_d !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bypass_cleanup: count=%0d hit_d=%0b, required 0/0", count, hit_d);
    end
  endtask

  // Push every cycle while draining every cycle: occupancy stays at 1 and
  // the pointers wrap several times.
  task automatic test_back_to_back();
    @(negedge clock);
    drain_hold = 1'b0;
    for (int i = 0; i < 10; i++) begin
      push_valid = 1'b1;
      push_addr  = 5'(i);
      push_data  = 32'(20 + i);
      #1;
      if (i > 0) begin
        checks++;
        if (rf_enable !== 1'b1 || rf_addr !== 5'(i - 1) || rf_data !== 32'(19 + i) || count !== 3'd1) begin
          errors++;
          $display("[TB] FAIL b2b_stream[%0d]: en=%0b addr=%0d data=%0d count=%0d, required 1/%0d/%0d/1", i, rf_enable, rf_addr, rf_data, count, i - 1, 19 + i);
        end
      end
      @(negedge clock);
    end
    push_valid = 1'b0;
    #1;
    checks++;
    if (rf_enable !== 1'b1 || rf_addr !== 5'd9 || rf_data !== 32'd29) begin
      errors++;
      $display("[TB] FAIL b2b_last: en=%0b addr=%0d data=%0d, required 1/9/29", rf_enable, rf_addr, rf_data);
    end
    @(negedge clock);
    checks++;
    if (rf_enable !== 1'b0 || count !== 3'd0) begin
      errors++;
      $display("[TB] FAIL b2b_empty: en=%0b count=%0d, required 0/0", rf_enable, count);
    end
  endtask

  // Reset while entries are draining discards everything still pending.
  task automatic test_reset_mid_drain();
    @(negedge clock);
    drain_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_valid = 1'b1;
      push_addr  = 5'(10 + i);
      push_data  = 32'(40 + i);
      @(negedge clock);
    end
    push_valid = 1'b0;
    drain_hold = 1'b0;
    #1;
    checks++;
    if (rf_enable !== 1'b1 || rf_addr !== 5'd10 || count !== 3'd3) begin
      errors++;
      $display("[TB] FAIL rst_mid_start: en=%0b addr=%0d count=%0d, required 1/10/3", rf_enable, rf_addr, count);
    end
    @(negedge clock);
    reset = 1'b1;
    look_addr_a = 5'd11;
    #1;
    checks++;
    if (rf_enable !== 1'b0 || rf_addr !== 5'd0 || push_ready !== 1'b0 || hit_a !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_mid_during: en=%0b addr=%0d push_ready=%0b hit_a=%0b, required 0/0/0/0", rf_enable, rf_addr, push_ready, hit_a);
    end
    @(negedge clock);
    reset = 1'b0;
    #1;
    checks++;
    if (count !== 3'd0 || rf_enable !== 1'b0 || hit_a !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_mid_after: count=%0d en=%0b hit_a=%0b, required 0/0/0", count, rf_enable, hit_a);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checks++;
      if (rf_enable !== 1'b0) begin
        errors++;
        $display("[TB] FAIL rst_mid_no_replay[%0d]: en=%0b addr=%0d, required 0", i, rf_enable, rf_addr);
      end
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    reset       = 1'b1;
    push_valid  = 1'b0;
    push_addr   = '0;
    push_data   = '0;
    drain_hold  = 1'b0;
    look_addr_a = '0;
    look_addr_b = '0;
    look_addr_d = '0;

    test_reset();
    test_single_push();
    test_fill_and_drain();
    test_bypass();
    test_back_to_back();
    test_reset_mid_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
